// File: rtl/fetch_redirect_ctrl.sv
// Front-end fetch sequencer: arbitrates redirects into the BPU, meters sequential
// fetch against fetch-queue credits and drains the fetch pipe after each redirect.
module fetch_redirect_ctrl #(
  parameter int FQ_DEPTH     = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmt_redirect_valid,
  input  logic [31:0]                   cmt_redirect_target,
  input  logic                          bru_redirect_valid,
  input  logic [31:0]                   bru_redirect_target,
  input  logic                          pdc_redirect_valid,
  input  logic [31:0]                   pdc_redirect_target,
  input  logic                          idle_req,
  input  logic                          icache_ready,
  input  logic                          fq_pop,
  output logic                          bpu_next,
  output logic                          bpu_redirect,
  output logic [31:0]                   bpu_target,
  output logic                          fetch_flush,
  output logic [$clog2(FQ_DEPTH+1)-1:0] credit,
  output logic [1:0]                    state
);

  localparam int CW = $clog2(FQ_DEPTH+1);
  localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_CYCLES-1);

  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, IDLE = 2'd2} state_t;

  state_t        st, st_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic [CW-1:0] credit_q, credit_nxt;
  logic [CW:0]   credit_sum;
  logic          any_v, accept;
  logic [31:0]   sel_target;

  always_comb begin
    sel_target = pdc_redirect_target;
    if (cmt_redirect_valid)      sel_target = cmt_redirect_target;
    else if (bru_redirect_valid) sel_target = bru_redirect_target;
  end

  assign any_v  = cmt_redirect_valid | bru_redirect_valid | pdc_redirect_valid;
  // While parked only a commit redirect may wake the front end.
  assign accept = rst_n & ((st == IDLE) ? cmt_redirect_valid : any_v);

  assign bpu_redirect = accept;
  assign bpu_target   = accept ? {sel_target[31:2], 2'b00} : 32'h0;
  assign bpu_next     = rst_n & (st == RUN) & icache_ready & (credit_q != '0)
                        & ~accept & ~idle_req;
  assign fetch_flush  = ~rst_n | accept | (st == FLUSH) | ((st == RUN) & idle_req);
  assign credit       = credit_q;
  assign state        = st;

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    case (st)
      RUN: begin
        if (accept) begin
          st_nxt  = FLUSH;
          cnt_nxt = CNT_RELOAD;
        end else if (idle_req) begin
          st_nxt = IDLE;
        end
      end
      FLUSH: begin
        if (accept)          cnt_nxt = CNT_RELOAD;
        else if (cnt == '0)  st_nxt  = RUN;
        else                 cnt_nxt = cnt - 3'd1;
      end
      IDLE: begin
        if (accept) begin
          st_nxt  = FLUSH;
          cnt_nxt = CNT_RELOAD;
        end
      end
      default: begin
        st_nxt  = FLUSH;
        cnt_nxt = CNT_RELOAD;
      end
    endcase
  end

  // A flush empties the queue, so any pop in that cycle refers to a discarded packet.
  always_comb begin
    credit_sum = {1'b0, credit_q} + (CW+1)'(fq_pop) - (CW+1)'(bpu_next);
    credit_nxt = credit_sum[CW-1:0];
    if (credit_sum > (CW+1)'(FQ_DEPTH)) credit_nxt = CW'(FQ_DEPTH);
    if (fetch_flush)                    credit_nxt = CW'(FQ_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= FLUSH;
      cnt      <= CNT_RELOAD;
      credit_q <= CW'(FQ_DEPTH);
    end else begin
      st       <= st_nxt;
      cnt      <= cnt_nxt;
      credit_q <= credit_nxt;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && !fetch_flush && fq_pop)
      assert (credit_q != CW'(FQ_DEPTH)) else $error("fq_pop with full credit");
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl with hand-computed expectations.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmt_v, bru_v, pdc_v;
  logic [31:0] cmt_t, bru_t, pdc_t;
  logic        idle_req, icache_ready, fq_pop;
  logic        bpu_next, bpu_redirect, fetch_flush;
  logic [31:0] bpu_target;
  logic [3:0]  credit;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.FQ_DEPTH(8), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmt_redirect_valid(cmt_v), .cmt_redirect_target(cmt_t),
    .bru_redirect_valid(bru_v), .bru_redirect_target(bru_t),
    .pdc_redirect_valid(pdc_v), .pdc_redirect_target(pdc_t),
    .idle_req(idle_req), .icache_ready(icache_ready), .fq_pop(fq_pop),
    .bpu_next(bpu_next), .bpu_redirect(bpu_redirect), .bpu_target(bpu_target),
    .fetch_flush(fetch_flush), .credit(credit), .state(state)
  );

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic clr;
    cmt_v = 0; bru_v = 0; pdc_v = 0; idle_req = 0; fq_pop = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; cmt_v = 1; cmt_t = 32'hffff_ffff; bru_v = 1; pdc_v = 1;
    idle_req = 1; icache_ready = 1; fq_pop = 1;
    cyc; #1;
    checks++; if (bpu_next !== 1'b0) begin failures++; $display("FAIL rst_next got=%b exp=0", bpu_next); end
    checks++; if (bpu_redirect !== 1'b0) begin failures++; $display("FAIL rst_redir got=%b exp=0", bpu_redirect); end
    checks++; if (bpu_target !== 32'h0) begin failures++; $display("FAIL rst_target got=%h exp=0", bpu_target); end
    checks++; if (fetch_flush !== 1'b1) begin failures++; $display("FAIL rst_flush got=%b exp=1", fetch_flush); end
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL rst_state got=%0d exp=1", state); end
    checks++; if (credit !== 4'd8) begin failures++; $display("FAIL rst_credit got=%0d exp=8", credit); end
    cyc;
    clr;
  endtask

  task automatic test_startup;
    rst_n = 1; icache_ready = 1; #1;
    for (int c = 0; c < 2; c++) begin
      checks++; if (state !== 2'd1) begin failures++; $display("FAIL start_flush_state c=%0d got=%0d exp=1", c, state); end
      checks++; if (bpu_next !== 1'b0 || fetch_flush !== 1'b1) begin failures++; $display("FAIL start_flush_out c=%0d next=%b flush=%b exp next=0 flush=1", c, bpu_next, fetch_flush); end
      cyc; #1;
    end
    for (int i = 0; i < 8; i++) begin
      checks++; if (state !== 2'd0 || bpu_next !== 1'b1) begin failures++; $display("FAIL start_issue i=%0d state=%0d next=%b exp state=0 next=1", i, state, bpu_next); end
      checks++; if (credit !== 4'(8-i)) begin failures++; $display("FAIL start_credit i=%0d got=%0d exp=%0d", i, credit, 8-i); end
      cyc; #1;
    end
    checks++; if (credit !== 4'd0 || bpu_next !== 1'b0 || fetch_flush !== 1'b0) begin failures++; $display("FAIL start_empty credit=%0d next=%b flush=%b exp 0/0/0", credit, bpu_next, fetch_flush); end
  endtask

  task automatic test_credit;
    fq_pop = 1; #1;
    checks++; if (bpu_next !== 1'b0) begin failures++; $display("FAIL cred_blocked got=%b exp=0", bpu_next); end
    cyc; fq_pop = 0; #1;
    checks++; if (credit !== 4'd1 || bpu_next !== 1'b1) begin failures++; $display("FAIL cred_pop credit=%0d next=%b exp 1/1", credit, bpu_next); end
    cyc; #1;
    checks++; if (credit !== 4'd0 || bpu_next !== 1'b0) begin failures++; $display("FAIL cred_one credit=%0d next=%b exp 0/0", credit, bpu_next); end
    fq_pop = 1;
    cyc; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (credit !== 4'd1 || bpu_next !== 1'b1) begin failures++; $display("FAIL cred_steady i=%0d credit=%0d next=%b exp 1/1", i, credit, bpu_next); end
      cyc; #1;
    end
    fq_pop = 0;
  endtask

  task automatic test_arb;
    cmt_v = 1; cmt_t = 32'h1c00_1003; bru_v = 1; bru_t = 32'h1c00_2000;
    pdc_v = 1; pdc_t = 32'h1c00_3000; #1;
    checks++; if (bpu_redirect !== 1'b1 || bpu_target !== 32'h1c00_1000) begin failures++; $display("FAIL arb_cmt redir=%b target=%h exp 1/1c001000", bpu_redirect, bpu_target); end
    checks++; if (fetch_flush !== 1'b1 || bpu_next !== 1'b0) begin failures++; $display("FAIL arb_flush flush=%b next=%b exp 1/0", fetch_flush, bpu_next); end
    cyc; clr; #1;
    checks++; if (state !== 2'd1 || credit !== 4'd8 || bpu_next !== 1'b0) begin failures++; $display("FAIL arb_t1 state=%0d credit=%0d next=%b exp 1/8/0", state, credit, bpu_next); end
    cyc; #1;
    checks++; if (state !== 2'd1 || bpu_next !== 1'b0) begin failures++; $display("FAIL arb_t2 state=%0d next=%b exp 1/0", state, bpu_next); end
    cyc; #1;
    checks++; if (state !== 2'd0 || bpu_next !== 1'b1) begin failures++; $display("FAIL arb_t3 state=%0d next=%b exp 0/1", state, bpu_next); end
  endtask

  task automatic test_flush_reload;
    pdc_v = 1; pdc_t = 32'h1c00_3002; #1;
    checks++; if (bpu_redirect !== 1'b1 || bpu_target !== 32'h1c00_3000) begin failures++; $display("FAIL rl_pdc redir=%b target=%h exp 1/1c003000", bpu_redirect, bpu_target); end
    cyc; bru_v = 1; bru_t = 32'h1c00_2000; #1;
    checks++; if (state !== 2'd1 || bpu_redirect !== 1'b1 || bpu_target !== 32'h1c00_2000) begin failures++; $display("FAIL rl_bru state=%0d redir=%b target=%h exp 1/1/1c002000", state, bpu_redirect, bpu_target); end
    cyc; clr; #1;
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL rl_c1 got=%0d exp=1", state); end
    cyc; #1;
    checks++; if (state !== 2'd1 || bpu_next !== 1'b0) begin failures++; $display("FAIL rl_c2 state=%0d next=%b exp 1/0", state, bpu_next); end
    cyc; #1;
    checks++; if (state !== 2'd0 || bpu_next !== 1'b1) begin failures++; $display("FAIL rl_run state=%0d next=%b exp 0/1", state, bpu_next); end
  endtask

  task automatic test_idle;
    idle_req = 1; #1;
    checks++; if (fetch_flush !== 1'b1 || bpu_next !== 1'b0) begin failures++; $display("FAIL idle_enter flush=%b next=%b exp 1/0", fetch_flush, bpu_next); end
    cyc; idle_req = 0; bru_v = 1; bru_t = 32'h1c00_4000; #1;
    checks++; if (state !== 2'd2 || bpu_next !== 1'b0) begin failures++; $display("FAIL idle_state state=%0d next=%b exp 2/0", state, bpu_next); end
    checks++; if (bpu_redirect !== 1'b0 || bpu_target !== 32'h0 || fetch_flush !== 1'b0) begin failures++; $display("FAIL idle_bru redir=%b target=%h flush=%b exp 0/0/0", bpu_redirect, bpu_target, fetch_flush); end
    cyc; bru_v = 0; pdc_v = 1; pdc_t = 32'h1c00_5000; idle_req = 1; #1;
    checks++; if (bpu_redirect !== 1'b0 || bpu_next !== 1'b0) begin failures++; $display("FAIL idle_pdc redir=%b next=%b exp 0/0", bpu_redirect, bpu_next); end
    cyc; clr; #1;
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL idle_hold got=%0d exp=2", state); end
    cmt_v = 1; cmt_t = 32'h1c00_0800; #1;
    checks++; if (bpu_redirect !== 1'b1 || bpu_target !== 32'h1c00_0800 || fetch_flush !== 1'b1) begin failures++; $display("FAIL idle_cmt redir=%b target=%h flush=%b exp 1/1c000800/1", bpu_redirect, bpu_target, fetch_flush); end
    cyc; clr; #1;
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL idle_wake got=%0d exp=1", state); end
    cyc; cyc; #1;
    checks++; if (state !== 2'd0 || bpu_next !== 1'b1) begin failures++; $display("FAIL idle_run state=%0d next=%b exp 0/1", state, bpu_next); end
    cmt_v = 1; cmt_t = 32'h1c00_0804; idle_req = 1; #1;
    checks++; if (bpu_redirect !== 1'b1 || bpu_target !== 32'h1c00_0804 || bpu_next !== 1'b0) begin failures++; $display("FAIL cmt_idle redir=%b target=%h next=%b exp 1/1c000804/0", bpu_redirect, bpu_target, bpu_next); end
    cyc; clr; #1;
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL cmt_idle_state got=%0d exp=1", state); end
    cyc; cyc; #1;
  endtask

  task automatic test_reset_mid;
    checks++; if (state !== 2'd0 || credit !== 4'd8) begin failures++; $display("FAIL mid_pre state=%0d credit=%0d exp 0/8", state, credit); end
    repeat (5) cyc;
    icache_ready = 0; #1;
    checks++; if (credit !== 4'd3) begin failures++; $display("FAIL mid_credit got=%0d exp=3", credit); end
    rst_n = 0; icache_ready = 1; pdc_v = 1; pdc_t = 32'h1c00_6000; #1;
    checks++; if (bpu_next !== 1'b0 || bpu_redirect !== 1'b0 || bpu_target !== 32'h0 || fetch_flush !== 1'b1) begin failures++; $display("FAIL mid_rst_out next=%b redir=%b target=%h flush=%b exp 0/0/0/1", bpu_next, bpu_redirect, bpu_target, fetch_flush); end
    cyc; #1;
    checks++; if (state !== 2'd1 || credit !== 4'd8) begin failures++; $display("FAIL mid_rst_state state=%0d credit=%0d exp 1/8", state, credit); end
    clr; rst_n = 1;
    cyc; cyc; idle_req = 1;
    cyc; idle_req = 0; #1;
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL idle_pre_rst got=%0d exp=2", state); end
    rst_n = 0; cmt_v = 1; cmt_t = 32'h1c00_7000; #1;
    checks++; if (bpu_redirect !== 1'b0 || bpu_target !== 32'h0 || fetch_flush !== 1'b1 || bpu_next !== 1'b0) begin failures++; $display("FAIL idle_rst_out redir=%b target=%h flush=%b next=%b exp 0/0/1/0", bpu_redirect, bpu_target, fetch_flush, bpu_next); end
    cyc; #1;
    checks++; if (state !== 2'd1 || credit !== 4'd8) begin failures++; $display("FAIL idle_rst_state state=%0d credit=%0d exp 1/8", state, credit); end
    clr; rst_n = 1;
    cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cmt_t = 0; bru_t = 0; pdc_t = 0;
    clr; icache_ready = 0; rst_n = 0;
    test_reset;
    test_startup;
    test_credit;
    test_arb;
    test_flush_reload;
    test_idle;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
